// File: rtl/bip_control_unit_pkg.sv
// Shared BIP control-unit definitions: field widths, opcodes, one-hot FSM states
// and the small decode helpers used by the sequencer.
package bip_control_unit_pkg;

    localparam int DB  = 16;
    localparam int OPW = 5;
    localparam int AW  = 11;
    localparam int PCW = 11;

    typedef enum logic [OPW-1:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111
    } opcode_t;

    typedef enum logic [4:0] {
        S_FETCH  = 5'b00001,
        S_DECODE = 5'b00010,
        S_MEM    = 5'b00100,
        S_EXEC   = 5'b01000,
        S_HALT   = 5'b10000
    } state_t;

    function automatic logic is_load(input logic [OPW-1:0] op);
        return (op == OP_LD) || (op == OP_LDI);
    endfunction

    function automatic logic needs_mem(input logic [OPW-1:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_imm(input logic [OPW-1:0] op);
        return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic is_neg(input logic [OPW-1:0] op);
        return (op == OP_SUB) || (op == OP_SUBI);
    endfunction

    function automatic logic writes_acc(input logic [OPW-1:0] op);
        return is_imm(op) || needs_mem(op);
    endfunction

    function automatic logic [DB-1:0] sext(input logic [AW-1:0] f);
        return {{(DB-AW){f[AW-1]}}, f};
    endfunction

    function automatic logic [DB-1:0] negate(input logic [DB-1:0] x);
        return ~x + DB'(1);
    endfunction

endpackage

// File: rtl/bip_control_unit_pc.sv
// Program counter for the BIP sequencer: async clear, increment, silent wrap.
module bip_pc
    import bip_control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           Reset,
    input  logic           inc,
    output logic [PCW-1:0] pc
);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            pc <= '0;
        else if (inc)
            pc <= pc + PCW'(1);
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP multi-cycle sequencer: fetches from synchronous ROM, decodes, and drives
// the add-only accumulator (clear-then-add loads, negated subtract operands).
module bip_control_unit
    import bip_control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           Reset,
    input  logic           Enable,
    input  logic [DB-1:0]  RomData,
    input  logic [DB-1:0]  RamRdData,
    input  logic [DB-1:0]  AccValue,
    output logic [PCW-1:0] RomAddr,
    output logic [AW-1:0]  RamAddr,
    output logic           RamRd,
    output logic           RamWr,
    output logic [DB-1:0]  RamWrData,
    output logic           AccClear,
    output logic           AccWr,
    output logic [DB-1:0]  Operand,
    output logic           Halted
);

    state_t         state;
    logic [DB-1:0]  ir;
    logic [OPW-1:0] ir_op;
    logic [OPW-1:0] rom_op;
    logic [PCW-1:0] pc;
    logic           pc_inc;

    assign ir_op     = ir[DB-1:AW];
    assign rom_op    = RomData[DB-1:AW];
    assign RomAddr   = pc;
    assign RamAddr   = ir[AW-1:0];
    assign RamWrData = AccValue;

    // PC advances on EXEC entry so the synchronous ROM already holds the next word in FETCH.
    assign pc_inc = (state == S_MEM) ||
                    ((state == S_DECODE) && (ir_op != OP_HLT) && !needs_mem(ir_op));

    bip_pc u_pc (
        .clk  (clk),
        .Reset(Reset),
        .inc  (pc_inc),
        .pc   (pc)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_FETCH;
            ir       <= '0;
            Operand  <= '0;
            RamRd    <= 1'b0;
            RamWr    <= 1'b0;
            AccClear <= 1'b0;
            AccWr    <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            RamRd    <= 1'b0;
            RamWr    <= 1'b0;
            AccClear <= 1'b0;
            AccWr    <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (Enable) begin
                        // Strobes are registered, so DECODE's strobes come from the word IR is loading.
                        ir       <= RomData;
                        AccClear <= is_load(rom_op);
                        RamRd    <= needs_mem(rom_op);
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir_op == OP_HLT) begin
                        Halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (needs_mem(ir_op)) begin
                        state <= S_MEM;
                    end else begin
                        if (is_imm(ir_op))
                            Operand <= is_neg(ir_op) ? negate(sext(ir[AW-1:0])) : sext(ir[AW-1:0]);
                        AccWr <= writes_acc(ir_op);
                        RamWr <= (ir_op == OP_STO);
                        state <= S_EXEC;
                    end
                end
                S_MEM: begin
                    Operand <= is_neg(ir_op) ? negate(RamRdData) : RamRdData;
                    AccWr   <= 1'b1;
                    state   <= S_EXEC;
                end
                S_EXEC:  state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
